// File: rtl/fifo_drain_pkg.sv
// Shared types and helpers for the FIFO burst drain controller.
// Holds the controller state encoding and the burst-length clamp.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CLEAR = 2'd2
  } drain_state_e;

  // A request of 0 words still drains one; requests beyond the FIFO depth drain the whole FIFO.
  function automatic int unsigned clamp_burst_length(input int unsigned requested,
                                                     input int unsigned depth);
    if (requested == 0) begin
      return 1;
    end
    if (requested > depth) begin
      return depth;
    end
    return requested;
  endfunction

endpackage

// File: rtl/fifo_burst_drain_controller.sv
// Read-side sequencer for a show-ahead FIFO: drains fixed-size or timed-out partial bursts
// onto a registered valid/ready stream and serialises FIFO clears between bursts.
module fifo_burst_drain_controller
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [ADDRESS_WIDTH:0]   burst_length,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  input  logic                     clear_request,
  input  logic [ADDRESS_WIDTH-1:0] fifo_data_count,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  input  logic [DATA_WIDTH-1:0]    fifo_read_data,
  output logic                     fifo_read_increment,
  output logic                     fifo_clear,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_last,
  output logic                     busy,
  output logic                     timeout_flush,
  output drain_state_e             dbg_state
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int          CW    = ADDRESS_WIDTH + 1;

  typedef logic [CW-1:0] occ_t;

  drain_state_e             state_q;
  occ_t                     words_remaining_q;
  logic [TIMEOUT_WIDTH-1:0] idle_count_q;
  logic                     clear_pending_q;
  logic                     m_valid_q;
  logic                     m_last_q;
  logic [DATA_WIDTH-1:0]    m_data_q;
  logic                     fifo_clear_q;
  logic                     timeout_flush_q;

  occ_t effective_count;
  occ_t burst_target;
  logic below_threshold;
  logic idle_count_max;
  logic timeout_hit;
  logic start_clear;
  logic start_full;
  logic start_partial;
  logic pop;

  // Occupancy needs one extra bit: a full FIFO reports a wrapped count of 0.
  assign effective_count = fifo_full ? occ_t'(DEPTH) : {1'b0, fifo_data_count};
  assign burst_target    = occ_t'(clamp_burst_length(32'(burst_length), DEPTH));
  assign below_threshold = effective_count < burst_target;
  assign idle_count_max  = &idle_count_q;
  assign timeout_hit     = (timeout_cycles != '0) && !fifo_empty && (idle_count_q >= timeout_cycles);

  // A pending clear blocks new bursts so it is serviced as soon as the stream register empties.
  assign start_clear   = (state_q == IDLE) && clear_pending_q && !m_valid_q;
  assign start_full    = (state_q == IDLE) && !clear_pending_q && enable && !below_threshold;
  assign start_partial = (state_q == IDLE) && !clear_pending_q && enable && below_threshold
                         && timeout_hit;

  // Stream handshake: a word transfers on a cycle where m_valid and m_ready are both high;
  // while m_valid is high and m_ready low, m_data/m_last/m_valid hold. A pop refills the
  // register whenever it is empty or being drained that same cycle.
  assign pop = (state_q == BURST) && (words_remaining_q != '0) && !fifo_empty
               && (!m_valid_q || m_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      words_remaining_q <= '0;
      idle_count_q      <= '0;
      clear_pending_q   <= 1'b0;
      m_valid_q         <= 1'b0;
      m_last_q          <= 1'b0;
      m_data_q          <= '0;
      fifo_clear_q      <= 1'b0;
      timeout_flush_q   <= 1'b0;
    end else begin
      fifo_clear_q    <= 1'b0;
      timeout_flush_q <= 1'b0;
      clear_pending_q <= (clear_pending_q && !start_clear) || clear_request;

      if ((state_q != IDLE) || fifo_empty || start_full || start_partial) begin
        idle_count_q <= '0;
      end else if (below_threshold && !idle_count_max) begin
        idle_count_q <= idle_count_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start_clear) begin
            state_q      <= CLEAR;
            fifo_clear_q <= 1'b1;
          end else if (start_full) begin
            state_q           <= BURST;
            words_remaining_q <= burst_target;
          end else if (start_partial) begin
            state_q           <= BURST;
            words_remaining_q <= effective_count;
            timeout_flush_q   <= 1'b1;
          end
        end
        BURST: begin
          if (pop) begin
            words_remaining_q <= words_remaining_q - 1'b1;
            if (words_remaining_q == occ_t'(1)) begin
              state_q <= IDLE;
            end
          end
        end
        CLEAR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (pop) begin
        m_data_q  <= fifo_read_data;
        m_valid_q <= 1'b1;
        m_last_q  <= (words_remaining_q == occ_t'(1));
      end else if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

  assign fifo_read_increment = pop;
  assign fifo_clear          = fifo_clear_q;
  assign m_valid             = m_valid_q;
  assign m_data              = m_data_q;
  assign m_last              = m_last_q;
  assign busy                = (state_q != IDLE) || m_valid_q;
  assign timeout_flush       = timeout_flush_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_fifo_burst_drain_controller.sv
// Bench for fifo_burst_drain_controller: a queue-based show-ahead FIFO feeds the DUT and a
// word/last scoreboard built from the burst rules checks the stream.
module tb_fifo_burst_drain_controller;
  import fifo_drain_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int TW    = 16;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [AW:0]   burst_length = '0;
  logic [TW-1:0] timeout_cycles = '0;
  logic          clear_request = 1'b0;
  logic [AW-1:0] fifo_data_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_read_data;
  logic          fifo_read_increment;
  logic          fifo_clear;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          timeout_flush;
  drain_state_e  dbg_state;

  fifo_burst_drain_controller #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .burst_length(burst_length),
    .timeout_cycles(timeout_cycles), .clear_request(clear_request),
    .fifo_data_count(fifo_data_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_read_data(fifo_read_data), .fifo_read_increment(fifo_read_increment),
    .fifo_clear(fifo_clear), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .timeout_flush(timeout_flush), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- state ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_pop = 0, n_hs = 0, n_flush = 0, n_clear = 0;
  int flush_cyc = 0, clear_cyc = 0, last_hs_cyc = 0;
  int pop_log[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW:0]   exp_q[$];     // {last, data}
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic          s_busy = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- FIFO model / driver tasks ----------------
  task automatic refresh_fifo();
    fifo_data_count = AW'(fifo_q.size());
    fifo_full       = (fifo_q.size() == DEPTH);
    fifo_empty      = (fifo_q.size() == 0);
    fifo_read_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    refresh_fifo();
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  function automatic int clamp_len(input int req);
    if (req == 0) return 1;
    if (req > DEPTH) return DEPTH;
    return req;
  endfunction

  // One clock cycle: monitor at the falling edge, then apply FIFO side effects after the rise.
  task automatic tick();
    logic pop_s, clr_s;
    logic [DW:0] e;
    @(negedge clock);
    cyc++;
    pop_s  = fifo_read_increment;
    clr_s  = fifo_clear;
    s_busy = busy;
    if (prev_stall) begin
      check("stall_valid", m_valid, 1);
      check("stall_data", m_data, prev_data);
      check("stall_last", m_last, prev_last);
    end
    if (pop_s) begin
      n_pop++;
      pop_log.push_back(cyc);
      check("pop_nonempty", fifo_q.size() != 0, 1);
      check("pop_not_stalled", m_valid && !m_ready, 0);
    end
    if (m_valid && m_ready) begin
      n_hs++;
      last_hs_cyc = cyc;
      check("sb_word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("m_data", m_data, e[DW-1:0]);
        check("m_last", m_last, e[DW]);
      end
    end
    if (timeout_flush) begin
      n_flush++;
      flush_cyc = cyc;
    end
    if (clr_s) begin
      n_clear++;
      clear_cyc = cyc;
      check("clear_valid_low", m_valid, 0);
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    @(posedge clock);
    #1;
    if (clr_s) fifo_q.delete();
    else if (pop_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh_fifo();
  endtask

  task automatic wait_hs(input int target, input int budget, input string tag);
    int n = 0;
    while (n_hs < target && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_hs_reached"}, n_hs >= target, 1);
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, (exp_q.size() == 0) && !busy, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int base_pop, base_hs, base_flush, base_clear, first_cyc, r, lc, nb, total, sent, n;
    refresh_fifo();
    repeat (2) @(posedge clock);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_pop", fifo_read_increment, 0);
    check("rst_clear", fifo_clear, 0);
    check("rst_busy", busy, 0);
    check("rst_flush", timeout_flush, 0);
    check("rst_state", dbg_state, IDLE);
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    check("post_rst_busy", s_busy, 0);

    // 1: four-word burst at full rate
    burst_length = 5'd4;
    pop_log.delete();
    base_hs = n_hs;
    for (int i = 0; i < 4; i++) begin
      push_word(32'hA0 + i);
      expect_word(32'hA0 + i, i == 3);
      tick();
    end
    wait_hs(base_hs + 4, 20, "t1");
    tick();
    check("t1_busy_low_after_last", s_busy, 0);
    check("t1_pop_count", pop_log.size(), 4);
    if (pop_log.size() == 4) check("t1_pops_consecutive", pop_log[3] - pop_log[0], 3);
    check("t1_fifo_empty", fifo_q.size(), 0);

    // enable low holds off a burst until it returns
    enable = 1'b0;
    base_pop = n_pop;
    for (int i = 0; i < 4; i++) begin
      push_word(32'hB0 + i);
      expect_word(32'hB0 + i, i == 3);
    end
    repeat (6) tick();
    check("en_low_no_pop", n_pop - base_pop, 0);
    enable = 1'b1;
    drain(30, "en");

    // 2: partial flush after timeout
    burst_length   = 5'd8;
    timeout_cycles = 16'd10;
    base_pop   = n_pop;
    base_flush = n_flush;
    for (int i = 0; i < 3; i++) begin
      push_word(32'hC0 + i);
      expect_word(32'hC0 + i, i == 2);
    end
    first_cyc = cyc + 1;
    drain(60, "t2");
    repeat (4) tick();
    check("t2_flush_count", n_flush - base_flush, 1);
    check("t2_flush_cycle", flush_cyc - first_cyc, 11);
    check("t2_pop_count", n_pop - base_pop, 3);
    timeout_cycles = '0;

    // 3: backpressure pattern 1,0,0,1
    burst_length = 5'd4;
    base_hs  = n_hs;
    base_pop = n_pop;
    for (int i = 0; i < 4; i++) begin
      push_word(32'hD0 + i);
      expect_word(32'hD0 + i, i == 3);
    end
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      m_ready = (n % 4 == 0) || (n % 4 == 3);
      tick();
      n++;
    end
    m_ready = 1'b1;
    check("t3_drained", exp_q.size(), 0);
    check("t3_handshakes", n_hs - base_hs, 4);
    check("t3_pops", n_pop - base_pop, 4);

    // 4a: burst_length 0 acts as 1
    burst_length = 5'd0;
    base_hs = n_hs;
    for (int i = 0; i < 3; i++) begin
      push_word(32'hE0 + i);
      expect_word(32'hE0 + i, 1'b1);
    end
    drain(40, "t4a");
    check("t4a_handshakes", n_hs - base_hs, 3);

    // 4b: burst_length 20 clamps to the depth
    burst_length = 5'd20;
    base_pop = n_pop;
    for (int i = 0; i < 15; i++) begin
      push_word(32'h100 + i);
      expect_word(32'h100 + i, 1'b0);
    end
    repeat (8) tick();
    check("t4b_no_start_below_full", n_pop - base_pop, 0);
    push_word(32'h10F);
    expect_word(32'h10F, 1'b1);
    drain(60, "t4b");
    check("t4b_pops", n_pop - base_pop, 16);

    // 5: clear requested mid-burst is deferred
    burst_length = 5'd4;
    base_hs    = n_hs;
    base_clear = n_clear;
    for (int i = 0; i < 4; i++) begin
      push_word(32'hF0 + i);
      expect_word(32'hF0 + i, i == 3);
    end
    wait_hs(base_hs + 1, 20, "t5");
    clear_request = 1'b1;
    tick();
    clear_request = 1'b0;
    drain(30, "t5");
    repeat (4) tick();
    check("t5_handshakes", n_hs - base_hs, 4);
    check("t5_clear_count", n_clear - base_clear, 1);
    check("t5_clear_after_stream", clear_cyc > last_hs_cyc, 1);

    // 6: asynchronous reset mid-burst
    base_hs = n_hs;
    for (int i = 0; i < 4; i++) begin
      push_word(32'h200 + i);
      expect_word(32'h200 + i, i == 3);
    end
    wait_hs(base_hs + 2, 20, "t6");
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", m_valid, 0);
    check("t6_async_last", m_last, 0);
    check("t6_async_data", m_data, 0);
    check("t6_async_pop", fifo_read_increment, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_state", dbg_state, IDLE);
    exp_q.delete();
    prev_stall = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("t6_state_idle", dbg_state, IDLE);
    base_pop = n_pop;
    repeat (5) tick();
    check("t6_no_restart_below_threshold", n_pop - base_pop, 0);
    r = fifo_q.size();
    for (int i = 0; i < r; i++) expect_word(fifo_q[i], i == 3);
    for (int i = r; i < 4; i++) begin
      push_word(32'h300 + i);
      expect_word(32'h300 + i, i == 3);
    end
    drain(30, "t6");
    check("t6_pops_after_restart", n_pop - base_pop, 4);

    // random: bursts of the clamped length with random arrivals and backpressure
    for (int it = 0; it < 6; it++) begin
      burst_length = AW'(0) + 5'($urandom_range(0, 20));
      lc    = clamp_len(int'(burst_length));
      nb    = $urandom_range(1, 3);
      total = nb * lc;
      sent  = 0;
      n     = 0;
      while ((sent < total || exp_q.size() != 0 || busy) && n < 2000) begin
        m_ready = ($urandom_range(0, 3) != 0);
        if (sent < total && fifo_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
          push_word($urandom());
          expect_word(fifo_q[fifo_q.size() - 1], ((sent + 1) % lc) == 0);
          sent++;
        end
        tick();
        n++;
      end
      m_ready = 1'b1;
      check("rand_all_sent", sent, total);
      check("rand_drained", exp_q.size(), 0);
      check("rand_fifo_empty", fifo_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_burst_drain_controller.md
Name: fifo_burst_drain_controller

Overview:
Sequences the read side of synchronous_fifo that buffers LTC2311-16 samples. It waits until a configurable number of words is buffered, or until a timeout expires with words still pending, and then pops exactly that many words. The words are presented on a registered valid/ready stream, and the last word of each burst is marked. It also owns the FIFO clear, so a clear can never land in the middle of a burst.

Parameters:
DATA_WIDTH, 32, FIFO word width.
ADDRESS_WIDTH, 4, FIFO address width; depth = 2**ADDRESS_WIDTH.
TIMEOUT_WIDTH, 16, width of the timeout counter and its config input.

Ports:
clock  input  1  single clock domain.
reset  input  1  asynchronous, active-high reset.
enable  input  1  when 0, no new burst starts; a running burst completes.
burst_length  input  ADDRESS_WIDTH+1  words per full burst; 0 is treated as 1; values above depth are clamped to depth; sampled at burst start.
timeout_cycles  input  TIMEOUT_WIDTH  idle cycles before a partial flush; 0 disables the timeout.
clear_request  input  1  one-cycle pulse requesting a FIFO clear.
fifo_data_count  input  ADDRESS_WIDTH  FIFO occupancy.
fifo_full  input  1  FIFO full; effective count = full ? depth : fifo_data_count.
fifo_empty  input  1  FIFO empty.
fifo_read_data  input  DATA_WIDTH  head word; valid whenever fifo_empty=0 (show-ahead).
fifo_read_increment  output  1  pop strobe.
fifo_clear  output  1  one-cycle FIFO clear pulse.
m_valid  output  1  stream valid.
m_ready  input  1  stream ready.
m_data  output  DATA_WIDTH  stream data.
m_last  output  1  marks the last word of a burst.
busy  output  1  high when the state is not IDLE or m_valid=1.
timeout_flush  output  1  one-cycle pulse when a partial burst starts.

Behaviour:
- Reset values: state=IDLE; m_valid=0; m_last=0; m_data=0; fifo_read_increment=0; fifo_clear=0; busy=0; timeout_flush=0; all counters 0; pending clear cleared.
- States: IDLE, BURST, CLEAR.
- IDLE -> CLEAR
  - Condition: a clear is pending and m_valid=0. Clear has priority over starting a burst.
  - In CLEAR, fifo_clear=1 for exactly one cycle and the timeout counter resets; the state returns to IDLE next cycle.
- IDLE -> BURST (full burst)
  - Condition: enable=1 and effective count >= clamped burst_length.
  - words_remaining is loaded with the clamped burst_length.
- IDLE -> BURST (partial burst)
  - Condition: enable=1, timeout_cycles!=0, FIFO non-empty, and the idle counter reaches timeout_cycles.
  - words_remaining is loaded with the effective count; timeout_flush pulses for one cycle.
- Idle counter:
  - Increments each IDLE cycle while the FIFO is non-empty and below threshold.
  - Clears when the FIFO is empty, on any burst start, and in CLEAR.
  - Saturates; never wraps.
- Pop rule: fifo_read_increment = (state==BURST) & words_remaining!=0 & !fifo_empty & (!m_valid | m_ready). It is combinational from registered state and the inputs.
- On a pop:
  - m_data <= fifo_read_data; m_valid <= 1; m_last <= (words_remaining==1); words_remaining decrements.
- Output register:
  - If m_valid & m_ready and there is no pop in the same cycle, m_valid <= 0.
  - If m_valid & !m_ready, m_data, m_valid and m_last hold stable. This is a stream protocol rule.
- BURST -> IDLE: the cycle the final pop occurs (words_remaining becomes 0).
- FIFO empties mid-burst (external clear elsewhere, or an underrun): the controller stalls in BURST, with no pop and no m_last, until data arrives. Underflow pops never occur.
- clear_request during BURST: latched as pending and serviced after the burst drains and m_valid=0.
- Throughput: with m_ready=1, one word per cycle.
- Latency:
  - Threshold met in cycle N: BURST and first pop in N+1, m_valid=1 in N+2.
  - Timeout with timeout_cycles=T, counter starting at the first non-empty IDLE cycle: first pop T+1 cycles later.
- Width rule: all occupancy comparisons use ADDRESS_WIDTH+1 bits.
- enable falling in BURST has no effect until IDLE.

Decomposition:
- Package fifo_drain_pkg: state enum type (IDLE, BURST, CLEAR) and a function that computes the clamped burst length.
- No sub-module is needed. The output register is local; the timeout counter is small enough to stay inline.

Test Plan:
1. DEPTH=16, burst_length=4, m_ready=1; write 4 words 0xA0..0xA3 -> 4 consecutive pops; m_data A0..A3; m_last only on A3; FIFO empty after; busy low 1 cycle after the last handshake.
2. burst_length=8, timeout_cycles=10; write 3 words then stop -> timeout_flush pulse 11 cycles after the first word; 3 words out, m_last on the 3rd; no 4th pop.
3. burst_length=4; m_ready toggled 1,0,0,1,... -> m_data stable while stalled; exactly 4 handshakes; no pop while m_valid & !m_ready.
4. burst_length=0 -> treated as 1, m_last on every word. burst_length=20 -> clamped to 16, start only when fifo_full=1, 16 words, m_last on the 16th.
5. clear_request pulsed on the 2nd word of a 4-word burst -> burst completes with all 4 words; fifo_clear pulses exactly once, after m_valid drops.
6. reset asserted mid-burst, after 2 of 4 words -> all outputs 0 asynchronously; after release, state IDLE; a new burst starts only once the threshold is met again.
